// File: rtl/date_bcd_counter.sv
// date_bcd_counter
//   Settable dd/mm/yy calendar counter (years 2000-2099) driving six BCD
//   display digits. Each accepted tick advances the date by one day, with
//   month-length and leap-year handling. A date load arrives through a
//   ready/valid handshake. It is captured in IDLE, validated in CHECK, and
//   then committed or rejected.
//
//   Ports
//     clk, rst         clock, synchronous active-high reset
//     tick             one-cycle advance-one-day pulse
//     hold             drops ticks while high (loads still accepted)
//     ld_valid/ld_*    load request with BCD day/month/year
//     ld_ready         load can be accepted (IDLE)
//     ld_done/ld_err   one-cycle result pulses for a load
//     year_wrap        one-cycle pulse on 99/12/31 -> 00/01/01
//     val0..val5       day ones/tens, month ones/tens, year ones/tens
module date_bcd_counter #(
  parameter logic [7:0] INIT_DD = 8'h01,
  parameter logic [7:0] INIT_MM = 8'h01,
  parameter logic [7:0] INIT_YY = 8'h19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       hold,
  input  logic       ld_valid,
  input  logic [7:0] ld_dd,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_yy,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       ld_err,
  output logic       year_wrap,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [3:0] val4,
  output logic [3:0] val5
);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t     state_q, state_d;
  logic [7:0] dd_q, dd_d, mm_q, mm_d, yy_q, yy_d;
  logic [7:0] cap_dd_q, cap_dd_d, cap_mm_q, cap_mm_d, cap_yy_q, cap_yy_d;
  logic       pending_q, pending_d;
  logic       ld_ready_q, ld_ready_d;
  logic       ld_done_q, ld_done_d;
  logic       ld_err_q, ld_err_d;
  logic       year_wrap_q, year_wrap_d;
  logic       advance;
  logic       tick_ok;
  logic       cap_ok;
  logic [7:0] cur_dim;

  // BCD +1 for a value that is known to stay below 99 on this path.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // yy % 4 == 0 tested on BCD digits: even tens need ones in {0,4,8},
  // odd tens need ones in {2,6}.
  function automatic logic is_leap(input logic [7:0] yy);
    if (yy[4]) return (yy[3:0] == 4'd2) || (yy[3:0] == 4'd6);
    return (yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8);
  endfunction

  // Days in month as a BCD byte, so it compares directly against dd.
  function automatic logic [7:0] dim(input logic [7:0] mm, input logic [7:0] yy);
    case (mm)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap(yy) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  assign tick_ok = tick & ~hold;
  assign cur_dim = dim(mm_q, yy_q);

  // BCD bytes with valid nibbles order the same way as their decimal values,
  // so plain unsigned compares are enough once every nibble is checked.
  assign cap_ok = (cap_dd_q[7:4] <= 4'd9) && (cap_dd_q[3:0] <= 4'd9) &&
                  (cap_mm_q[7:4] <= 4'd9) && (cap_mm_q[3:0] <= 4'd9) &&
                  (cap_yy_q[7:4] <= 4'd9) && (cap_yy_q[3:0] <= 4'd9) &&
                  (cap_mm_q >= 8'h01) && (cap_mm_q <= 8'h12) &&
                  (cap_dd_q >= 8'h01) && (cap_dd_q <= dim(cap_mm_q, cap_yy_q));

  always_comb begin
    state_d     = state_q;
    dd_d        = dd_q;
    mm_d        = mm_q;
    yy_d        = yy_q;
    cap_dd_d    = cap_dd_q;
    cap_mm_d    = cap_mm_q;
    cap_yy_d    = cap_yy_q;
    pending_d   = pending_q;
    ld_ready_d  = ld_ready_q;
    ld_done_d   = 1'b0;
    ld_err_d    = 1'b0;
    year_wrap_d = 1'b0;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          // Load wins; a coincident tick waits until the load resolves.
          cap_dd_d   = ld_dd;
          cap_mm_d   = ld_mm;
          cap_yy_d   = ld_yy;
          state_d    = CHECK;
          ld_ready_d = 1'b0;
          pending_d  = pending_q | tick_ok;
        end else if (pending_q | tick_ok) begin
          // A pended tick and a fresh tick in the same cycle count once.
          advance   = 1'b1;
          pending_d = 1'b0;
        end
      end
      CHECK: begin
        state_d    = IDLE;
        ld_ready_d = 1'b1;
        pending_d  = pending_q | tick_ok;
        if (cap_ok) begin
          dd_d      = cap_dd_q;
          mm_d      = cap_mm_q;
          yy_d      = cap_yy_q;
          ld_done_d = 1'b1;
        end else begin
          ld_err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (dd_q < cur_dim) begin
        dd_d = bcd_inc(dd_q);
      end else begin
        dd_d = 8'h01;
        if (mm_q == 8'h12) begin
          mm_d = 8'h01;
          if (yy_q == 8'h99) begin
            yy_d        = 8'h00;
            year_wrap_d = 1'b1;
          end else begin
            yy_d = bcd_inc(yy_q);
          end
        end else begin
          mm_d = bcd_inc(mm_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dd_q        <= INIT_DD;
      mm_q        <= INIT_MM;
      yy_q        <= INIT_YY;
      cap_dd_q    <= 8'h00;
      cap_mm_q    <= 8'h00;
      cap_yy_q    <= 8'h00;
      pending_q   <= 1'b0;
      ld_ready_q  <= 1'b1;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      year_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dd_q        <= dd_d;
      mm_q        <= mm_d;
      yy_q        <= yy_d;
      cap_dd_q    <= cap_dd_d;
      cap_mm_q    <= cap_mm_d;
      cap_yy_q    <= cap_yy_d;
      pending_q   <= pending_d;
      ld_ready_q  <= ld_ready_d;
      ld_done_q   <= ld_done_d;
      ld_err_q    <= ld_err_d;
      year_wrap_q <= year_wrap_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign ld_err    = ld_err_q;
  assign year_wrap = year_wrap_q;
  assign val0      = dd_q[3:0];
  assign val1      = dd_q[7:4];
  assign val2      = mm_q[3:0];
  assign val3      = mm_q[7:4];
  assign val4      = yy_q[3:0];
  assign val5      = yy_q[7:4];

endmodule
